// File: rtl/neuron_mac.sv
// neuron_mac: one fixed-point neuron.
// The block multiplies num_inputs operand pairs and sums the products onto a
// bias in a double-width accumulator. The sum is then clamped to the word
// range, passed through ReLU, and held until the consumer accepts it.

// Fixed-point multiplier: the full-precision product is shifted right
// arithmetically by the number of fractional bits (floor), then wrapped to
// the word width.
module fxp_mult #(
  parameter int bits            = 16,
  parameter int fractional_bits = 8
) (
  input  logic signed [bits-1:0] A,
  input  logic signed [bits-1:0] B,
  output logic signed [bits-1:0] Product
);

  logic signed [2*bits-1:0] a_ext_s;
  logic signed [2*bits-1:0] b_ext_s;
  logic signed [2*bits-1:0] full_s;

  assign a_ext_s = {{bits{A[bits-1]}}, A};
  assign b_ext_s = {{bits{B[bits-1]}}, B};
  assign full_s  = a_ext_s * b_ext_s;
  assign Product = bits'(full_s >>> fractional_bits);

endmodule

module neuron_mac #(
  parameter int bits            = 16,
  parameter int fractional_bits = 8,
  parameter int num_inputs      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [bits-1:0] bias,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [bits-1:0] in_data,
  input  logic signed [bits-1:0] in_weight,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [bits-1:0] out_data,
  output logic                   busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] ACT   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Counter wide enough to hold num_inputs itself.
  localparam int cw = (num_inputs < 1) ? 1 : $clog2(num_inputs + 1);
  localparam logic [cw-1:0] count_last = cw'(num_inputs - 1);
  localparam logic [cw-1:0] count_one  = cw'(1'b1);

  // Word range expressed at accumulator width for clamping.
  localparam logic signed [2*bits-1:0] sat_max = {{(bits+1){1'b0}}, {(bits-1){1'b1}}};
  localparam logic signed [2*bits-1:0] sat_min = {{(bits+1){1'b1}}, {(bits-1){1'b0}}};

  logic [1:0]               state_r;
  logic [1:0]               state_next_s;
  logic signed [2*bits-1:0] acc_r;
  logic [cw-1:0]            count_r;
  logic signed [bits-1:0]   product_s;
  logic signed [2*bits-1:0] product_ext_s;
  logic signed [2*bits-1:0] bias_ext_s;
  logic signed [bits-1:0]   clamp_s;
  logic signed [bits-1:0]   relu_s;
  logic                     transfer_s;

  fxp_mult #(
    .bits            (bits),
    .fractional_bits (fractional_bits)
  ) u_mult (
    .A       (in_data),
    .B       (in_weight),
    .Product (product_s)
  );

  assign product_ext_s = {{bits{product_s[bits-1]}}, product_s};
  assign bias_ext_s    = {{bits{bias[bits-1]}}, bias};

  // Next-state logic and operand handshake decode.
  always_comb begin
    state_next_s = state_r;
    transfer_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          transfer_s = 1'b1;
          if (count_r == count_last) begin
            state_next_s = ACT;
          end else begin
            state_next_s = ACCUM;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      ACT: begin
        state_next_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Clamp the accumulator to the word range, then apply ReLU.
  always_comb begin
    clamp_s = bits'(acc_r);
    if (acc_r > sat_max) begin
      clamp_s = bits'(sat_max);
    end else if (acc_r < sat_min) begin
      clamp_s = bits'(sat_min);
    end else begin
      clamp_s = bits'(acc_r);
    end
    if (clamp_s[bits-1]) begin
      relu_s = '0;
    end else begin
      relu_s = clamp_s;
    end
  end

  // State register and registered status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      in_ready  <= (state_next_s == ACCUM);
      out_valid <= (state_next_s == DONE);
      busy      <= (state_next_s != IDLE);
    end
  end

  // Datapath: bias load, product accumulation and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= '0;
      count_r  <= '0;
      out_data <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r   <= bias_ext_s;
            count_r <= '0;
          end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
          end
        end
        ACCUM: begin
          if (transfer_s) begin
            acc_r   <= acc_r + product_ext_s;
            count_r <= count_r + count_one;
          end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
          end
        end
        ACT: begin
          out_data <= relu_s;
        end
        default: begin
          acc_r    <= acc_r;
          count_r  <= count_r;
          out_data <= out_data;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed bench for neuron_mac (bits=16, fractional_bits=8,
// num_inputs=4) with a transaction-level reference model.
`timescale 1ns/1ps
module tb_neuron_mac;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [15:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic signed [15:0] in_weight;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               busy;

  int checks = 0;
  int errors = 0;

  neuron_mac #(
    .bits            (16),
    .fractional_bits (8),
    .num_inputs      (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Q8.8 product: floor(a*w / 256), wrapped to 16 bits.
  function automatic longint fx_mul(input longint a, input longint w);
    longint p;
    logic signed [15:0] t;
    p = (a * w) >>> 8;
    t = p[15:0];
    return longint'(t);
  endfunction

  // Clamp to the 16-bit range, then ReLU.
  function automatic longint neuron_out(input longint s);
    if (s > 32767) return 32767;
    if (s < 0) return 0;
    return s;
  endfunction

  // Reference model state: what the outputs must be in the current cycle.
  bit     exp_in_ready  = 1'b0;
  bit     exp_out_valid = 1'b0;
  bit     exp_busy      = 1'b0;
  bit     act_pending   = 1'b0;
  longint exp_data      = 0;
  longint m_sum         = 0;
  int     m_n           = 0;
  int     n_xfer        = 0;
  int     n_results     = 0;
  bit     prev_ov       = 1'b0;

  // Compare the DUT against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (rst) begin
      exp_in_ready  = 1'b0;
      exp_out_valid = 1'b0;
      exp_busy      = 1'b0;
      act_pending   = 1'b0;
    end
    check("model_in_ready", in_ready, exp_in_ready);
    check("model_out_valid", out_valid, exp_out_valid);
    check("model_busy", busy, exp_busy);
    if (exp_out_valid) check("model_out_data", out_data, exp_data);
    if (out_valid && !prev_ov) n_results++;
    prev_ov = out_valid;
    if (!rst) begin
      if (in_valid && in_ready) n_xfer++;
      if (!exp_busy && start) begin
        m_sum        = bias;
        m_n          = 0;
        exp_in_ready = 1'b1;
        exp_busy     = 1'b1;
      end else if (exp_in_ready && in_valid) begin
        m_sum = m_sum + fx_mul(in_data, in_weight);
        m_n++;
        if (m_n == N) begin
          exp_in_ready = 1'b0;
          act_pending  = 1'b1;
        end
      end else if (act_pending) begin
        act_pending   = 1'b0;
        exp_data      = neuron_out(m_sum);
        exp_out_valid = 1'b1;
      end else if (exp_out_valid && out_ready) begin
        exp_out_valid = 1'b0;
        exp_busy      = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic signed [15:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
    check("start_to_in_ready", in_ready, 1);
  endtask

  task automatic send_pair(input logic signed [15:0] a, input logic signed [15:0] w);
    in_valid  = 1'b1;
    in_data   = a;
    in_weight = w;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("out_valid_timeout", out_valid, 1);
  endtask

  // Last transfer just happened: ACT now, DONE next cycle.
  task automatic finish_run(input string name, input longint req);
    check({name, "_act_out_valid"}, out_valid, 0);
    check({name, "_act_in_ready"}, in_ready, 0);
    tick();
    check({name, "_latency"}, out_valid, 1);
    check({name, "_out_data"}, out_data, req);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_out_valid"}, out_valid, 0);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic run_uniform(input string name, input logic signed [15:0] b,
                             input logic signed [15:0] a, input logic signed [15:0] w,
                             input longint req);
    do_start(b);
    for (int i = 0; i < N; i++) send_pair(a, w);
    finish_run(name, req);
  endtask

  int x0;
  int r0;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_weight = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;
    tick();
    check("post_reset_busy", busy, 0);

    // Basic, negative and saturating sums.
    x0 = n_xfer;
    run_uniform("basic", 16'sd0, 16'sd256, 16'sd128, 512);
    check("basic_transfers", n_xfer - x0, 4);
    run_uniform("negative", -16'sd256, 16'sd256, -16'sd128, 0);
    run_uniform("saturate", 16'sd0, 16'sd25600, 16'sd256, 32767);

    // Mixed signs with floor behaviour: 384 - 128 - 118 + 11 + 100 = 249.
    do_start(16'sd100);
    send_pair(16'sd384, 16'sd256);
    send_pair(-16'sd512, 16'sd64);
    send_pair(16'sd100, -16'sd300);
    send_pair(16'sd1000, 16'sd3);
    finish_run("mixed", 249);

    // Gapped input and output backpressure.
    x0 = n_xfer;
    do_start(16'sd0);
    in_data   = 16'sd256;
    in_weight = 16'sd128;
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    check("gap_ready_before_last", in_ready, 1);
    in_valid = 1'b1; tick();
    in_valid = 1'b0;
    check("gap_transfers", n_xfer - x0, 4);
    check("gap_ready_after_last", in_ready, 0);
    tick();
    check("gap_latency", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("gap_hold_valid", out_valid, 1);
      check("gap_hold_data", out_data, 512);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("gap_idle_busy", busy, 0);
    check("gap_idle_valid", out_valid, 0);
    check("gap_no_extra_transfers", n_xfer - x0, 4);

    // Reset in the middle of accumulation.
    do_start(16'sd0);
    send_pair(16'sd256, 16'sd128);
    send_pair(16'sd256, 16'sd128);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_after_busy", busy, 0);
    run_uniform("rerun", 16'sd0, 16'sd256, 16'sd128, 512);

    // start held high for a whole evaluation, including the handshake cycle.
    r0 = n_results;
    start = 1'b1;
    bias  = 16'sd0;
    tick();
    check("held_start_ready", in_ready, 1);
    for (int i = 0; i < N; i++) begin
      in_valid  = 1'b1;
      in_data   = 16'sd256;
      in_weight = 16'sd128;
      tick();
    end
    in_valid = 1'b0;
    wait_valid();
    tick();
    check("held_done_data", out_data, 512);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("held_idle_busy", busy, 0);
    tick();
    tick();
    check("held_no_second_busy", busy, 0);
    check("held_one_result", n_results - r0, 1);
    run_uniform("second", 16'sd0, 16'sd256, 16'sd128, 512);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
